// File: rtl/tt_div_pkg.sv
// Shared definitions for the tt_um_divider tile.
//   - FSM state encoding (enum plus plain logic constants for the state register)
//   - bit positions of the status flags on uio_out
//   - output-enable mask for the bidirectional pins
package tt_div_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GOT_A = 2'd1,
        S_BUSY  = 2'd2,
        S_DONE  = 2'd3
    } div_state_e;

    localparam logic [1:0] ST_IDLE  = S_IDLE;
    localparam logic [1:0] ST_GOT_A = S_GOT_A;
    localparam logic [1:0] ST_BUSY  = S_BUSY;
    localparam logic [1:0] ST_DONE  = S_DONE;

    localparam int BUSY_BIT  = 2;
    localparam int DONE_BIT  = 3;
    localparam int DZ_BIT    = 4;
    localparam int AWAIT_BIT = 5;

    localparam logic [7:0] UIO_OE_MASK = 8'h3C;

endpackage

// File: rtl/tt_div_core.sv
// Iterative unsigned restoring divider datapath, one quotient bit per clock.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start           load operands and begin a division (one-cycle pulse)
//   divisor_zero    qualifies start: produce the divide-by-zero result instead
//   dividend_in     dividend captured on start
//   divisor_in      divisor captured on start
//   busy            division in progress
//   valid           high in the cycle whose closing edge commits the results
//   quotient        quotient result register (holds previous result while busy)
//   remainder       remainder result register (holds previous result while busy)
module tt_div_core
    import tt_div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             divisor_zero,
    input  logic [WIDTH-1:0] dividend_in,
    input  logic [WIDTH-1:0] divisor_in,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] qacc;
    logic [CNT_W-1:0] cnt;
    logic             zero_pend;

    logic [WIDTH:0]   trial;
    logic             fits;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] q_next;

    // The partial remainder is always below the divisor, so the shifted trial
    // value needs one extra bit and the restored difference fits back in WIDTH.
    always_comb begin
        trial    = {rem, dvd[WIDTH-1]};
        fits     = (trial >= {1'b0, dvs});
        rem_next = fits ? WIDTH'(trial - {1'b0, dvs}) : trial[WIDTH-1:0];
        q_next   = {qacc[WIDTH-2:0], fits};
    end

    // Divide-by-zero spends a single busy cycle so both paths report through valid.
    assign valid = busy & (zero_pend | (cnt == CNT_W'(1)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dvd       <= '0;
            dvs       <= '0;
            rem       <= '0;
            qacc      <= '0;
            cnt       <= '0;
            zero_pend <= 1'b0;
            busy      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else if (start) begin
            dvd       <= dividend_in;
            dvs       <= divisor_in;
            rem       <= '0;
            qacc      <= '0;
            cnt       <= CNT_W'(WIDTH);
            zero_pend <= divisor_zero;
            busy      <= 1'b1;
        end else if (busy) begin
            if (zero_pend) begin
                quotient  <= '1;
                remainder <= dvd;
                zero_pend <= 1'b0;
                busy      <= 1'b0;
            end else begin
                dvd  <= {dvd[WIDTH-2:0], 1'b0};
                rem  <= rem_next;
                qacc <= q_next;
                cnt  <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    quotient  <= q_next;
                    remainder <= rem_next;
                    busy      <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/tt_um_divider.sv
// TinyTapeout tile: sequential unsigned restoring divider.
// Operands are loaded byte-wise on ui_in, each on a rising edge of uio_in[0]
// (dividend first, then divisor); the quotient or remainder appears on uo_out.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   ena          ignored
//   ui_in        operand byte (WIDTH LSBs used)
//   uio_in       [0] load strobe, [1] result select (0 quotient, 1 remainder)
//   uo_out       selected result, zero-extended
//   uio_out      [2] busy, [3] done, [4] div_by_zero, [5] await_divisor
//   uio_oe       constant 8'h3C
// Build option: define TT_DIV_SYNC_EN to pass uio_in[1:0] through a 2-flop
// synchronizer before use (adds 2 cycles to every strobe-referenced latency).
module tt_um_divider
    import tt_div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic             strb;
    logic             sel;
    logic             strb_ok;
    logic             strb_q;
    logic             armed;
    logic             rise;
    logic [1:0]       state;
    logic [WIDTH-1:0] dividend;
    logic             dz_pend;
    logic             div_by_zero;
    logic             core_start;
    logic             core_busy;
    logic             core_valid;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

`ifdef TT_DIV_SYNC_EN
    logic [1:0] strb_sync;
    logic [1:0] sel_sync;
    logic [1:0] ok_sync;

    // ok_sync tracks when the synchronizer holds genuine pin samples again
    // after reset, so its reset zeros are not mistaken for a low strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            strb_sync <= 2'b00;
            sel_sync  <= 2'b00;
            ok_sync   <= 2'b00;
        end else begin
            strb_sync <= {strb_sync[0], uio_in[0]};
            sel_sync  <= {sel_sync[0], uio_in[1]};
            ok_sync   <= {ok_sync[0], 1'b1};
        end
    end

    assign strb    = strb_sync[1];
    assign sel     = sel_sync[1];
    assign strb_ok = ok_sync[1];
`else
    assign strb    = uio_in[0];
    assign sel     = uio_in[1];
    assign strb_ok = 1'b1;
`endif

    // armed stays low until the strobe has been seen low after reset, so a
    // strobe held high through reset release never counts as a rise.
    assign rise       = strb & ~strb_q & armed;
    assign core_start = (state == ST_GOT_A) & rise;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            strb_q      <= 1'b0;
            armed       <= 1'b0;
            state       <= ST_IDLE;
            dividend    <= '0;
            dz_pend     <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            strb_q <= strb;
            armed  <= armed | (strb_ok & ~strb);
            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        dividend <= ui_in[WIDTH-1:0];
                        state    <= ST_GOT_A;
                    end
                end
                ST_GOT_A: begin
                    if (rise) begin
                        dz_pend <= (ui_in[WIDTH-1:0] == '0);
                        state   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (core_valid) begin
                        div_by_zero <= dz_pend;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (rise) begin
                        dividend    <= ui_in[WIDTH-1:0];
                        div_by_zero <= 1'b0;
                        state       <= ST_GOT_A;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    tt_div_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (core_start),
        .divisor_zero(ui_in[WIDTH-1:0] == '0),
        .dividend_in (dividend),
        .divisor_in  (ui_in[WIDTH-1:0]),
        .busy        (core_busy),
        .valid       (core_valid),
        .quotient    (quotient),
        .remainder   (remainder)
    );

    assign uo_out = sel ? 8'(remainder) : 8'(quotient);

    always_comb begin
        uio_out            = 8'h00;
        uio_out[BUSY_BIT]  = (state == ST_BUSY);
        uio_out[DONE_BIT]  = (state == ST_DONE);
        uio_out[DZ_BIT]    = div_by_zero;
        uio_out[AWAIT_BIT] = (state == ST_GOT_A);
    end

    assign uio_oe = UIO_OE_MASK;

    logic unused;
    assign unused = &{1'b0, ena, ui_in, uio_in, core_busy};

endmodule

// File: tb/tb_tt_um_divider.sv
// Self-checking bench for tt_um_divider: directed cases plus randomized
// operands, compared against a plain-arithmetic model of the divider.
module tb_tt_um_divider;

    localparam int W = 8;
`ifdef TT_DIV_SYNC_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int   n_total = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   t_rise = 0;
    int   t_done = 0;
    logic done_d = 1'b0;
    int   prev_q = 0;
    int   prev_r = 0;

    tt_um_divider #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record the cycle in which done first rises.
    always @(negedge clk) begin
        if (uio_out[3] && !done_d) t_done = cyc;
        done_d = uio_out[3];
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One strobe pulse; ui_in stays put afterwards so a synchronized rise
    // still sees the same operand.
    task automatic strobe(input int v);
        @(negedge clk);
        ui_in     = v[7:0];
        uio_in[0] = 1'b1;
        @(negedge clk);
        uio_in[0] = 1'b0;
        t_rise    = cyc;
        repeat (EXTRA) @(negedge clk);
        #1;
    endtask

    task automatic read_result(input bit sel, output int v);
        @(negedge clk);
        uio_in[1] = sel;
        repeat (EXTRA) @(negedge clk);
        #1;
        v = uo_out;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (uio_out[3]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        check_val("done_seen", int'(ok), 1);
    endtask

    task automatic run_div(input int a, input int b, input bit extra);
        int exp_q, exp_r, exp_lat, v;
        if (b == 0) begin
            exp_q   = (1 << W) - 1;
            exp_r   = a;
            exp_lat = 1 + EXTRA;
        end else begin
            exp_q   = a / b;
            exp_r   = a % b;
            exp_lat = W + EXTRA;
        end

        strobe(a);
        check_val("await_a", int'(uio_out[5]), 1);
        check_val("dz_clr", int'(uio_out[4]), 0);

        strobe(b);
        check_val("busy", int'(uio_out[2]), 1);
        check_val("hold_prev", int'(uo_out), prev_q);

        if (extra) begin
            ui_in = 8'd100; uio_in[0] = 1'b1;
            @(negedge clk); uio_in[0] = 1'b0;
            @(negedge clk); ui_in = 8'd9; uio_in[0] = 1'b1;
            @(negedge clk); uio_in[0] = 1'b0;
            #1;
        end

        wait_done();
        check_val("latency", t_done - t_rise, exp_lat);
        check_val("await_done", int'(uio_out[5]), 0);
        check_val("busy_done", int'(uio_out[2]), 0);
        check_val("dz", int'(uio_out[4]), (b == 0) ? 1 : 0);
        read_result(1'b1, v);
        check_val("rem", v, exp_r);
        read_result(1'b0, v);
        check_val("quo", v, exp_q);
        prev_q = exp_q;
        prev_r = exp_r;
    endtask

    initial begin
        int a, b;

        repeat (3) @(negedge clk);
        #1;
        check_val("rst_uo", int'(uo_out), 0);
        check_val("rst_uio", int'(uio_out), 0);
        check_val("uio_oe", int'(uio_oe), 8'h3C);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        run_div(200, 7, 1'b0);
        run_div(255, 1, 1'b0);
        run_div(3, 10, 1'b0);
        run_div(5, 0, 1'b0);
        run_div(9, 2, 1'b0);
        run_div(100, 9, 1'b1);

        // Reset mid-division, strobe held high across release.
        strobe(200);
        strobe(7);
        repeat (2) @(negedge clk);
        rst_n     = 1'b0;
        ui_in     = 8'd77;
        uio_in[0] = 1'b1;
        @(negedge clk);
        #1;
        check_val("midrst_uo", int'(uo_out), 0);
        check_val("midrst_uio", int'(uio_out), 0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        check_val("held_noload", int'(uio_out), 0);
        check_val("held_uo", int'(uo_out), 0);
        uio_in[0] = 1'b0;
        prev_q = 0;
        prev_r = 0;
        repeat (EXTRA + 1) @(negedge clk);
        run_div(12, 4, 1'b0);

        for (int i = 0; i < 25; i++) begin
            a = $urandom_range(0, 255);
            b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
            run_div(a, b, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
